// File: rtl/bta_err_mon.sv
// Accuracy monitor for the bta approximate adder: compares each approximate sum
// against the exact sum and accumulates windowed error statistics.
module bta_err_mon #(
  parameter int DWA  = 16,
  parameter int DWB  = 16,
  parameter int DWO  = (DWA > DWB) ? DWA : DWB,
  parameter int CNTW = 16,
  parameter int ACCW = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CNTW-1:0]   i_win_len,
  input  logic              i_vld,
  input  logic [DWA-1:0]    i_a,
  input  logic [DWB-1:0]    i_b,
  input  logic [DWO-1:0]    i_c,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNTW-1:0]   o_cnt,
  output logic [ACCW-1:0]   o_err_sum,
  output logic [DWO:0]      o_err_max,
  output logic [CNTW-1:0]   o_mis_cnt
);

  localparam int EW   = DWO + 1;
  localparam int SUMW = ACCW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // |a + b - c| evaluated in signed DWO+2 bits so a dropped carry in c shows up.
  function automatic logic [EW-1:0] abs_err(input logic [DWO-1:0] a_ext,
                                            input logic [DWO-1:0] b_ext,
                                            input logic [DWO-1:0] c);
    logic [DWO+1:0] diff;
    logic [DWO+1:0] mag;
    diff = {2'b00, a_ext} + {2'b00, b_ext} - {2'b00, c};
    if (diff[DWO+1]) begin
      mag = ~diff + {{(DWO+1){1'b0}}, 1'b1};
    end else begin
      mag = diff;
    end
    return mag[EW-1:0];
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNTW-1:0]   r_win_len;
  logic [CNTW-1:0]   r_cnt;
  logic              r_s1_vld;
  logic [EW-1:0]     r_s1_err;
  logic              r_s2_vld;
  logic [EW-1:0]     r_s2_err;
  logic [ACCW-1:0]   r_err_sum;
  logic [EW-1:0]     r_err_max;
  logic [CNTW-1:0]   r_mis_cnt;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_accept;
  logic              w_last;
  logic [EW-1:0]     w_err;
  logic [SUMW-1:0]   w_sum_ext;

  assign w_start   = (r_state == ST_IDLE) && i_start;
  assign w_accept  = (r_state == ST_RUN) && i_vld && (r_cnt < r_win_len);
  assign w_last    = w_accept && ((r_cnt + CNTW'(1)) == r_win_len);
  assign w_err     = abs_err(DWO'(i_a), DWO'(i_b), i_c);
  assign w_sum_ext = {1'b0, r_err_sum} + SUMW'(r_s2_err);

  // Next-state logic for the window controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((r_cnt == r_win_len) || w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!r_s1_vld && !r_s2_vld) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, window length, sample count and registered status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_win_len <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_start) begin
        r_win_len <= i_win_len;
        r_cnt     <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  // Two-stage error pipeline; a new window flushes anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= '0;
      r_s2_vld <= 1'b0;
      r_s2_err <= '0;
    end else if (w_start) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      r_s1_err <= w_err;
      r_s2_vld <= r_s1_vld;
      r_s2_err <= r_s1_err;
    end
  end

  // Accumulators: saturating error sum, strict-greater max, mismatch count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sum <= '0;
      r_err_max <= '0;
      r_mis_cnt <= '0;
    end else if (w_start) begin
      r_err_sum <= '0;
      r_err_max <= '0;
      r_mis_cnt <= '0;
    end else if (r_s2_vld) begin
      r_err_sum <= w_sum_ext[ACCW] ? {ACCW{1'b1}} : w_sum_ext[ACCW-1:0];
      if (r_s2_err > r_err_max) begin
        r_err_max <= r_s2_err;
      end
      if (r_s2_err != '0) begin
        r_mis_cnt <= r_mis_cnt + CNTW'(1);
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cnt     = r_cnt;
  assign o_err_sum = r_err_sum;
  assign o_err_max = r_err_max;
  assign o_mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_bta_err_mon.sv
// Directed bench for bta_err_mon; a second instance with a 17-bit accumulator
// shares the stimulus to exercise error-sum saturation.
module tb_bta_err_mon;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] win_len;
  logic        vld;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;

  logic        busy;
  logic        done;
  logic [15:0] cnt;
  logic [31:0] err_sum;
  logic [16:0] err_max;
  logic [15:0] mis_cnt;

  logic        busy_s;
  logic        done_s;
  logic [15:0] cnt_s;
  logic [16:0] err_sum_s;
  logic [16:0] err_max_s;
  logic [15:0] mis_cnt_s;

  int checks = 0;
  int errors = 0;
  int n;

  bta_err_mon dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_win_len(win_len),
    .i_vld(vld), .i_a(a), .i_b(b), .i_c(c),
    .o_busy(busy), .o_done(done), .o_cnt(cnt), .o_err_sum(err_sum),
    .o_err_max(err_max), .o_mis_cnt(mis_cnt)
  );

  bta_err_mon #(.ACCW(17)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_win_len(win_len),
    .i_vld(vld), .i_a(a), .i_b(b), .i_c(c),
    .o_busy(busy_s), .o_done(done_s), .o_cnt(cnt_s), .o_err_sum(err_sum_s),
    .o_err_max(err_max_s), .o_mis_cnt(mis_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input logic [15:0] len);
    start   = 1'b1;
    win_len = len;
    step();
    start   = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!done && cycles < 20);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; win_len = 16'd0; vld = 1'b0;
    a = 16'd0; b = 16'd0; c = 16'd0;
    repeat (2) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_sum", 64'(err_sum), 64'd0);
    chk("rst_max", 64'(err_max), 64'd0);
    chk("rst_mis", 64'(mis_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // exact results
    start_win(16'd4);
    a = 16'h00FF; b = 16'h0001; c = 16'h0100; vld = 1'b1;
    repeat (4) step();
    vld = 1'b0;
    wait_done(n);
    chk("t1_done_lat", 64'(n), 64'd3);
    chk("t1_cnt", 64'(cnt), 64'd4);
    chk("t1_sum", 64'(err_sum), 64'd0);
    chk("t1_max", 64'(err_max), 64'd0);
    chk("t1_mis", 64'(mis_cnt), 64'd0);
    step();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // mixed errors, with pipeline latency
    start_win(16'd3);
    vld = 1'b1;
    a = 16'h0010; b = 16'h0010; c = 16'h0000;
    step();
    chk("t2_cnt_k", 64'(cnt), 64'd1);
    chk("t2_sum_k", 64'(err_sum), 64'd0);
    a = 16'h0100; b = 16'h0001; c = 16'h0100;
    step();
    chk("t2_sum_k1", 64'(err_sum), 64'd0);
    a = 16'h1234; b = 16'h0000; c = 16'h1234;
    step();
    vld = 1'b0;
    chk("t2_sum_k2", 64'(err_sum), 64'h20);
    chk("t2_cnt", 64'(cnt), 64'd3);
    wait_done(n);
    chk("t2_done_lat", 64'(n), 64'd3);
    chk("t2_sum", 64'(err_sum), 64'h21);
    chk("t2_max", 64'(err_max), 64'h20);
    chk("t2_mis", 64'(mis_cnt), 64'd2);
    step();

    // carry loss and saturation
    start_win(16'd2);
    a = 16'hFFFF; b = 16'h0001; c = 16'h0000; vld = 1'b1;
    repeat (2) step();
    vld = 1'b0;
    wait_done(n);
    chk("t3_done_lat", 64'(n), 64'd3);
    chk("t3_max", 64'(err_max), 64'h10000);
    chk("t3_sum", 64'(err_sum), 64'h20000);
    chk("t3_sum_sat", 64'(err_sum_s), 64'h1FFFF);
    chk("t3_max_sat", 64'(err_max_s), 64'h10000);
    chk("t3_mis", 64'(mis_cnt), 64'd2);
    step();

    // window overrun with gaps
    start_win(16'd2);
    a = 16'h0001; b = 16'h0001; c = 16'h0000;
    begin
      logic [4:0] pat;
      pat = 5'b11101;
      for (int i = 0; i < 5; i++) begin
        vld = pat[i];
        step();
        if (i >= 3) chk("t4_no_early_done", 64'(done), 64'd0);
      end
    end
    vld = 1'b0;
    step();
    chk("t4_done_at_k3", 64'(done), 64'd1);
    chk("t4_cnt", 64'(cnt), 64'd2);
    chk("t4_sum", 64'(err_sum), 64'd4);
    chk("t4_mis", 64'(mis_cnt), 64'd2);
    step();
    chk("t4_done_pulse", 64'(done), 64'd0);

    // zero window, start pulsed in DRAIN
    start_win(16'd0);
    step();
    chk("t5_drain_busy", 64'(busy), 64'd1);
    start = 1'b1; win_len = 16'd7;
    step();
    start = 1'b0;
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_cnt", 64'(cnt), 64'd0);
    chk("t5_sum", 64'(err_sum), 64'd0);
    chk("t5_max", 64'(err_max), 64'd0);
    chk("t5_mis", 64'(mis_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_second_done", 64'(done), 64'd0);
      chk("t5_idle", 64'(busy), 64'd0);
    end

    // reset mid-window
    start_win(16'd5);
    a = 16'h0010; b = 16'h0010; c = 16'h0000; vld = 1'b1;
    repeat (3) step();
    vld = 1'b0;
    chk("t6_pre_cnt", 64'(cnt), 64'd3);
    chk("t6_pre_sum", 64'(err_sum), 64'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cnt", 64'(cnt), 64'd0);
    chk("t6_rst_sum", 64'(err_sum), 64'd0);
    chk("t6_rst_max", 64'(err_max), 64'd0);
    chk("t6_rst_mis", 64'(mis_cnt), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_done", 64'(done), 64'd0);
    end
    start_win(16'd1);
    a = 16'h0003; b = 16'h0004; c = 16'h0005; vld = 1'b1;
    step();
    vld = 1'b0;
    wait_done(n);
    chk("t6_done_lat", 64'(n), 64'd3);
    chk("t6_cnt", 64'(cnt), 64'd1);
    chk("t6_sum", 64'(err_sum), 64'd2);
    chk("t6_max", 64'(err_max), 64'd2);
    chk("t6_mis", 64'(mis_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
